pgm_gfx_ddram_resp: RTL and testbench
=====================================

Name: pgm_gfx_ddram_resp

Overview:
Responder end of the graphics-ROM read interface (ddram_rd/ddram_addr/ddram_dout/ddram_busy/ddram_dout_ready) used by the PGM video engine. Accepts one 64-bit-word read at a time, serves it from a single-entry last-word cache or from the MiSTer DDR3 Avalon port, and returns the data with a one-cycle ready pulse. Sits between pgm_video and the top-level DDRAM port.

Parameters:
BASE_ADDR, 29'h0300000, 64-bit-word offset added to every request address (graphics ROM region in DDR3).
CACHE_EN, 1, 1 = last-word cache enabled; 0 = every request goes to DDR3.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
ddram_rd  in  1  read request level from the requester; held high until ddram_dout_ready is seen.
ddram_addr  in  29  64-bit-word address; sampled when the request is accepted.
ddram_dout  out  64  read data; valid in the ddram_dout_ready cycle, held until the next response.
ddram_busy  out  1  high whenever a request is not accepted this cycle.
ddram_dout_ready  out  1  one-cycle pulse: ddram_dout valid.
cache_inv  in  1  pulse: invalidate the cache (ROM reload or write).
mem_addr  out  29  DDR3 word address (ddram_addr + BASE_ADDR, modulo 2^29).
mem_burstcnt  out  8  constant 8'd1.
mem_rd  out  1  Avalon read; held until accepted (mem_rd & !mem_busy).
mem_dout  in  64  DDR3 read data.
mem_dout_ready  in  1  DDR3 read-data valid.
mem_busy  in  1  Avalon waitrequest.

Behaviour:
- Reset values: ddram_dout=0, ddram_dout_ready=0, ddram_busy=1 during the reset cycle and 0 afterwards if state=IDLE, mem_rd=0, mem_addr=0, cache valid=0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN, DISCARD. ddram_busy is registered and is 1 in every state except IDLE.
- IDLE: when ddram_rd=1, latch ddram_addr.
  - On a cache hit (CACHE_EN, valid, tag==addr, and no cache_inv in the same cycle): load ddram_dout from the cache and go to RESP. ddram_dout_ready pulses in the next cycle (1-cycle hit latency).
  - On a miss: go to ISSUE.
- ISSUE: mem_rd=1, mem_addr=latched+BASE_ADDR. Stay while mem_busy=1. On acceptance, drop mem_rd the next cycle, set the outstanding flag, and go to WAIT.
- WAIT: on mem_dout_ready, register mem_dout into ddram_dout and the cache data, update the tag, set valid, clear outstanding, and go to RESP.
- RESP: ddram_dout_ready=1 for exactly this cycle, then go to DRAIN.
- DRAIN: stay until ddram_rd=0, then go to IDLE. A held ddram_rd is never treated as a second request. If ddram_rd is already low in RESP, DRAIN lasts 1 cycle.
- Miss latency: request seen in IDLE at cycle N; mem_rd at N+1; ddram_dout_ready one cycle after mem_dout_ready.
- cache_inv: clears valid in any state. If it coincides with a WAIT-state fill, valid ends at 0 but the data is still returned to the requester.
- mem_dout_ready outside WAIT/DISCARD is ignored.
- Address arithmetic: 29-bit wrap, no carry out.
- Reset mid-operation: state goes to DISCARD if outstanding=1, otherwise IDLE.
  - The outstanding flag has an initial value of 0 and is not cleared by reset.
  - DISCARD waits for one mem_dout_ready, drops that data (no cache fill, no ddram_dout_ready), clears outstanding, and goes to IDLE.
  - mem_rd is cleared by reset even during ISSUE; an unaccepted read is abandoned and outstanding stays 0.
- Only one read is ever outstanding on the memory side.

Test Plan:
1. Miss: ddram_addr=29'h10, ddram_rd=1, mem_busy=0, mem_dout_ready 4 cycles after accept with 64'hDEAD_BEEF_0123_4567 -> mem_addr=29'h0300010, mem_burstcnt=1, single ddram_dout_ready one cycle later with that data, ddram_busy high from the accept cycle until DRAIN exits.
2. Hit: repeat addr 29'h10 after ddram_rd drops -> no mem_rd, ddram_dout_ready 1 cycle after request, same data; addr 29'h11 -> mem_rd issued.
3. Waitrequest: mem_busy high 6 cycles -> mem_rd and mem_addr stable all 6 cycles, exactly one accept, one response.
4. Held request: requester keeps ddram_rd high 5 cycles past dout_ready -> no second mem_rd, no second ddram_dout_ready, ddram_busy=1 until ddram_rd falls.
5. Invalidate: cache_inv pulse between two reads of 29'h10 -> second read misses and goes to DDR3; cache_inv during WAIT -> data returned, next same-address read misses.
6. Reset in WAIT: reset asserted, then mem_dout_ready arrives 3 cycles later -> no ddram_dout_ready, no cache fill; next request is serviced normally with fresh data.

Source files
------------

// File: rtl/pgm_gfx_ddram_resp.sv
// Graphics-ROM read responder: single-entry last-word cache in front of the DDR3 Avalon port.
// state     | meaning
// S_IDLE    | ready for a request; hit answers from cache, miss goes to ISSUE
// S_ISSUE   | mem_rd held until waitrequest drops
// S_WAIT    | one read outstanding, waiting for mem_dout_ready
// S_RESP    | ddram_dout_ready pulse cycle
// S_DRAIN   | waiting for the requester to drop ddram_rd
// S_DISCARD | after reset: swallow the orphaned read return
module pgm_gfx_ddram_resp #(
  parameter logic [28:0] BASE_ADDR = 29'h0300000,
  parameter int          CACHE_EN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ddram_rd,
  input  logic [28:0] ddram_addr,
  output logic [63:0] ddram_dout,
  output logic        ddram_busy,
  output logic        ddram_dout_ready,
  input  logic        cache_inv,
  output logic [28:0] mem_addr,
  output logic [7:0]  mem_burstcnt,
  output logic        mem_rd,
  input  logic [63:0] mem_dout,
  input  logic        mem_dout_ready,
  input  logic        mem_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN, S_DISCARD
  } state_t;

  state_t      r_state;
  logic [28:0] r_addr;
  logic [28:0] r_tag;
  logic [63:0] r_cdata;
  logic        r_valid;
  // Tracks the memory side, so it must survive reset.
  logic        r_outstanding = 1'b0;

  logic w_hit;
  logic w_accept;

  assign w_hit        = (CACHE_EN != 0) && r_valid && (r_tag == ddram_addr) && !cache_inv;
  assign w_accept     = mem_rd && !mem_busy;
  assign mem_burstcnt = 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ddram_dout       <= '0;
      ddram_dout_ready <= 1'b0;
      ddram_busy       <= 1'b1;
      mem_rd           <= 1'b0;
      mem_addr         <= '0;
      r_valid          <= 1'b0;
      // A read accepted on the reset edge is still owed a return.
      if (r_state == S_ISSUE && w_accept) begin
        r_outstanding <= 1'b1;
        r_state       <= S_DISCARD;
      end else if (r_outstanding && mem_dout_ready &&
                   (r_state == S_WAIT || r_state == S_DISCARD)) begin
        r_outstanding <= 1'b0;
        r_state       <= S_IDLE;
      end else begin
        r_state <= r_outstanding ? S_DISCARD : S_IDLE;
      end
    end else begin
      ddram_dout_ready <= 1'b0;
      if (cache_inv) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (ddram_rd && !ddram_busy) begin
            r_addr     <= ddram_addr;
            ddram_busy <= 1'b1;
            if (w_hit) begin
              ddram_dout       <= r_cdata;
              ddram_dout_ready <= 1'b1;
              r_state          <= S_RESP;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= ddram_addr + BASE_ADDR;
              r_state  <= S_ISSUE;
            end
          end else begin
            ddram_busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (!mem_busy) begin
            mem_rd        <= 1'b0;
            r_outstanding <= 1'b1;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_dout_ready) begin
            ddram_dout       <= mem_dout;
            r_cdata          <= mem_dout;
            r_tag            <= r_addr;
            r_valid          <= !cache_inv;
            r_outstanding    <= 1'b0;
            ddram_dout_ready <= 1'b1;
            r_state          <= S_RESP;
          end
        end
        S_RESP: r_state <= S_DRAIN;
        S_DRAIN: begin
          if (!ddram_rd) begin
            ddram_busy <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (mem_dout_ready) begin
            r_outstanding <= 1'b0;
            ddram_busy    <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pgm_gfx_ddram_resp.sv
// Scenario bench for pgm_gfx_ddram_resp: expected read data queued at request time, popped on each ready pulse.
module tb_pgm_gfx_ddram_resp;

  logic        clk = 1'b0;
  logic        reset, ddram_rd, cache_inv, mem_dout_ready, mem_busy;
  logic [28:0] ddram_addr, mem_addr;
  logic [63:0] ddram_dout, mem_dout;
  logic        ddram_busy, ddram_dout_ready, mem_rd;
  logic [7:0]  mem_burstcnt;

  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;
  int          n_rdy  = 0;
  logic [28:0] acc_addr;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  pgm_gfx_ddram_resp dut (
    .clk(clk), .reset(reset),
    .ddram_rd(ddram_rd), .ddram_addr(ddram_addr), .ddram_dout(ddram_dout),
    .ddram_busy(ddram_busy), .ddram_dout_ready(ddram_dout_ready), .cache_inv(cache_inv),
    .mem_addr(mem_addr), .mem_burstcnt(mem_burstcnt), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  // Memory-side accept counter and response scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_rd && !mem_busy) begin
      n_acc++;
      acc_addr = mem_addr;
    end
    if (ddram_dout_ready) begin
      n_rdy++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: dout=%h, no response expected", ddram_dout);
      end else begin
        e = exp_q.pop_front();
        if (ddram_dout !== e) begin
          errors++;
          $display("FAIL resp_data: got %h expected %h", ddram_dout, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int budget, output bit ok);
    int s;
    s  = n_acc;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (n_acc != s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic end_read(output bit ok);
    ddram_rd = 1'b0;
    ok       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!ddram_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drives a request that must miss; returns with the DUT in its response cycle.
  task automatic miss_read(input logic [28:0] a, input logic [63:0] d, input int lat,
                           input bit inv, output bit ok);
    ddram_addr = a;
    ddram_rd   = 1'b1;
    exp_q.push_back(d);
    wait_acc(40, ok);
    if (ok) begin
      step(lat - 1);
      mem_dout       = d;
      mem_dout_ready = 1'b1;
      cache_inv      = inv;
      step(1);
      mem_dout_ready = 1'b0;
      cache_inv      = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ddram_rd = 1'b0; ddram_addr = '0; cache_inv = 1'b0;
    mem_dout = '0; mem_dout_ready = 1'b0; mem_busy = 1'b0;
    step(2);
    checks++; if (ddram_dout !== 64'd0) begin errors++; $display("FAIL rst_dout: got %h expected 0", ddram_dout); end
    checks++; if (ddram_dout_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ddram_dout_ready); end
    checks++; if (ddram_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", ddram_busy); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd: got %b expected 0", mem_rd); end
    checks++; if (mem_addr !== 29'd0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    reset = 1'b0;
    step(1);
    checks++; if (ddram_busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b expected 0", ddram_busy); end
  endtask

  task automatic test_miss;
    int a0, r0;
    bit ok;
    a0 = n_acc; r0 = n_rdy;
    miss_read(29'h10, 64'hDEAD_BEEF_0123_4567, 4, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL miss_accept: no mem accept within budget"); end
    checks++; if (acc_addr !== 29'h0300010) begin errors++; $display("FAIL miss_mem_addr: got %h expected 0300010", acc_addr); end
    checks++; if (mem_burstcnt !== 8'd1) begin errors++; $display("FAIL miss_burstcnt: got %0d expected 1", mem_burstcnt); end
    checks++; if (ddram_dout_ready !== 1'b1) begin errors++; $display("FAIL miss_ready_latency: got %b expected 1", ddram_dout_ready); end
    checks++; if (ddram_busy !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL miss_resp_state: busy=%b mem_rd=%b expected 1/0", ddram_busy, mem_rd); end
    step(1);
    checks++; if (ddram_busy !== 1'b1 || ddram_dout_ready !== 1'b0) begin errors++; $display("FAIL miss_drain: busy=%b ready=%b expected 1/0", ddram_busy, ddram_dout_ready); end
    end_read(ok);
    checks++; if (!ok) begin errors++; $display("FAIL miss_release: busy still high after ddram_rd dropped"); end
    checks++; if (n_acc - a0 != 1 || n_rdy - r0 != 1) begin errors++; $display("FAIL miss_counts: accepts=%0d readies=%0d expected 1/1", n_acc - a0, n_rdy - r0); end
  endtask

  task automatic test_hit;
    int a0;
    bit ok;
    a0 = n_acc;
    ddram_addr = 29'h10;
    ddram_rd   = 1'b1;
    exp_q.push_back(64'hDEAD_BEEF_0123_4567);
    step(1);
    checks++; if (ddram_dout_ready !== 1'b1) begin errors++; $display("FAIL hit_latency: ready=%b expected 1", ddram_dout_ready); end
    end_read(ok);
    checks++; if (!ok || n_acc != a0) begin errors++; $display("FAIL hit_no_mem: release=%b accepts=%0d expected 1/0", ok, n_acc - a0); end
    miss_read(29'h11, 64'h0011_2233_4455_6677, 2, 1'b0, ok);
    checks++; if (!ok || acc_addr !== 29'h0300011) begin errors++; $display("FAIL hit_neighbor_miss: accepted=%b addr=%h expected 1/0300011", ok, acc_addr); end
    end_read(ok);
  endtask

  task automatic test_waitrequest;
    int a0, r0;
    bit ok, stable;
    a0 = n_acc; r0 = n_rdy;
    mem_busy   = 1'b1;
    ddram_addr = 29'h20;
    ddram_rd   = 1'b1;
    exp_q.push_back(64'h2020_3030_4040_5050);
    step(1);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (mem_rd !== 1'b1 || mem_addr !== 29'h0300020) stable = 1'b0;
      step(1);
    end
    checks++; if (!stable || n_acc != a0) begin errors++; $display("FAIL wr_hold: stable=%b accepts=%0d expected 1/0", stable, n_acc - a0); end
    mem_busy = 1'b0;
    wait_acc(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_accept: no accept after waitrequest dropped"); end
    step(2);
    mem_dout = 64'h2020_3030_4040_5050;
    mem_dout_ready = 1'b1;
    step(1);
    mem_dout_ready = 1'b0;
    checks++; if (ddram_dout_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", ddram_dout_ready); end
    end_read(ok);
    checks++; if (n_acc - a0 != 1 || n_rdy - r0 != 1) begin errors++; $display("FAIL wr_counts: accepts=%0d readies=%0d expected 1/1", n_acc - a0, n_rdy - r0); end
  endtask

  task automatic test_held_request;
    int a0, r0;
    bit ok, held;
    a0 = n_acc; r0 = n_rdy;
    miss_read(29'h30, 64'h3333_4444_5555_6666, 3, 1'b0, ok);
    checks++; if (!ok || ddram_dout_ready !== 1'b1) begin errors++; $display("FAIL held_first: accepted=%b ready=%b expected 1/1", ok, ddram_dout_ready); end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (ddram_busy !== 1'b1) held = 1'b0;
    end
    checks++; if (!held) begin errors++; $display("FAIL held_busy: busy dropped while ddram_rd held"); end
    checks++; if (n_acc - a0 != 1 || n_rdy - r0 != 1) begin errors++; $display("FAIL held_counts: accepts=%0d readies=%0d expected 1/1", n_acc - a0, n_rdy - r0); end
    end_read(ok);
    checks++; if (!ok) begin errors++; $display("FAIL held_release: busy still high after ddram_rd dropped"); end
  endtask

  task automatic test_invalidate;
    bit ok;
    miss_read(29'h10, 64'hA5A5_A5A5_0000_0001, 2, 1'b0, ok);
    end_read(ok);
    cache_inv = 1'b1;
    step(1);
    cache_inv = 1'b0;
    miss_read(29'h10, 64'hA5A5_A5A5_0000_0002, 2, 1'b0, ok);
    checks++; if (!ok || acc_addr !== 29'h0300010) begin errors++; $display("FAIL inv_miss: accepted=%b addr=%h expected 1/0300010", ok, acc_addr); end
    end_read(ok);
    miss_read(29'h40, 64'hC0C0_C0C0_0000_0003, 3, 1'b1, ok);
    checks++; if (ddram_dout_ready !== 1'b1) begin errors++; $display("FAIL inv_fill_ready: got %b expected 1", ddram_dout_ready); end
    end_read(ok);
    miss_read(29'h40, 64'hC0C0_C0C0_0000_0004, 2, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL inv_fill_miss: repeat read did not go to memory"); end
    end_read(ok);
  endtask

  task automatic test_reset_in_wait;
    int r0;
    bit ok;
    r0 = n_rdy;
    ddram_addr = 29'h50;
    ddram_rd   = 1'b1;
    wait_acc(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rw_accept: no mem accept within budget"); end
    step(1);
    reset    = 1'b1;
    ddram_rd = 1'b0;
    step(1);
    reset = 1'b0;
    step(1);
    checks++; if (ddram_busy !== 1'b1) begin errors++; $display("FAIL rw_discard_busy: got %b expected 1", ddram_busy); end
    step(1);
    mem_dout       = 64'hBAD0_BAD0_BAD0_BAD0;
    mem_dout_ready = 1'b1;
    step(1);
    mem_dout_ready = 1'b0;
    checks++; if (ddram_dout_ready !== 1'b0) begin errors++; $display("FAIL rw_no_ready: got %b expected 0", ddram_dout_ready); end
    step(1);
    checks++; if (ddram_busy !== 1'b0 || n_rdy != r0) begin errors++; $display("FAIL rw_idle: busy=%b readies=%0d expected 0/0", ddram_busy, n_rdy - r0); end
    miss_read(29'h50, 64'h5050_5050_FEED_F00D, 2, 1'b0, ok);
    checks++; if (!ok || acc_addr !== 29'h0300050) begin errors++; $display("FAIL rw_fresh: accepted=%b addr=%h expected 1/0300050", ok, acc_addr); end
    end_read(ok);
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_waitrequest();
    test_held_request();
    test_invalidate();
    test_reset_in_wait();
    step(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_resp: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
